mc_control_fsm: RTL

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_ctrl_pkg.sv | 43 ++++
 rtl/mc_ctrl_decode.sv | 84 ++++++++
 rtl/mc_control_fsm.sv | 94 +++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes and mux/ALU codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  // Instruction opcodes recognised in DECODE.
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU control class.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Second ALU operand select.
  localparam logic [1:0] ALUSRCB_REG   = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

  // Next-PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decoder: maps a state code to every datapath control signal.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] State,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB
);

  // Per-state output table; illegal codes fall through with everything at 0.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = ALUSRCB_REG;
    case (State)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = ALUSRCB_FOUR;
      end
      S_DECODE: ALUSrcB = ALUSRCB_BRIMM;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle processor control FSM: state register, opcode capture and next-state logic.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] Opcode,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           MemtoReg,
  output logic           IRWrite,
  output logic           ALUSrcA,
  output logic           RegWrite,
  output logic           RegDst,
  output logic [1:0]     PCSource,
  output logic [1:0]     ALUOp,
  output logic [1:0]     ALUSrcB,
  output logic [3:0]     State
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic [3:0]     dec_state;

  logic dec_pcwrite, dec_pcwritecond, dec_memwrite, dec_regwrite, dec_irwrite;

  // State register; reset returns to FETCH from anywhere, even mid-instruction.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Opcode is captured once in DECODE so MEMADR branches on the decoded instruction.
  always_ff @(posedge CLK) begin
    // NOTE: this register is cleared by reset because MEMADR reads it; a stale value would misroute.
    if (RST)                     op_q <= '0;
    else if (state_q == S_DECODE) op_q <= Opcode;
  end

  // Next-state logic; anything unexpected, including illegal codes, returns to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if      (Opcode == OPW'(OP_LW) || Opcode == OPW'(OP_SW)) state_d = S_MEMADR;
        else if (Opcode == OPW'(OP_RTYPE))                        state_d = S_EXEC;
        else if (Opcode == OPW'(OP_BEQ))                          state_d = S_BRANCH;
        else if (Opcode == OPW'(OP_J))                            state_d = S_JUMP;
        else if (Opcode == OPW'(OP_ADDI))                         state_d = S_ADDIEX;
        else                                                      state_d = S_FETCH;
      end
      S_MEMADR: state_d = (op_q == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // While reset is high the decoder sees FETCH, and the write enables are masked below.
  assign dec_state = RST ? S_FETCH : state_q;

  mc_ctrl_decode u_decode (
    .State       (dec_state),
    .PCWrite     (dec_pcwrite),
    .PCWriteCond (dec_pcwritecond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (dec_memwrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (dec_irwrite),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (dec_regwrite),
    .RegDst      (RegDst),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB)
  );

  assign PCWrite     = dec_pcwrite     & ~RST;
  assign PCWriteCond = dec_pcwritecond & ~RST;
  assign MemWrite    = dec_memwrite    & ~RST;
  assign RegWrite    = dec_regwrite    & ~RST;
  assign IRWrite     = dec_irwrite     & ~RST;
  assign State       = state_q;

endmodule
